// File: rtl/iagc_cmd_decoder.sv
// Command front end for the IAGC controller: frames SYNC/CMD/CHK byte packets from
// the host UART and holds the decoded command until the control FSM accepts it.
module iagc_cmd_decoder #(
    parameter int                    DATA_SIZE        = 8,
    parameter int                    STATUS_SIZE      = 4,
    parameter int                    CMD_PARAM_SIZE   = 4,
    parameter logic [DATA_SIZE-1:0]  SYNC_BYTE        = 8'hA5,
    parameter int                    TIMEOUT_CYCLES   = 1000,
    parameter int                    ERR_COUNT_SIZE   = 8,
    parameter logic [STATUS_SIZE-1:0] STATUS_CMD_PARSE = 4'b0100
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic [DATA_SIZE-1:0]      i_rx_data,
    input  logic                      i_rx_valid,
    input  logic [STATUS_SIZE-1:0]    i_status,
    output logic                      o_cmd_valid,
    output logic                      o_cmd_reset,
    output logic                      o_cmd_sample,
    output logic                      o_cmd_dump_mem,
    output logic                      o_cmd_clean_mem,
    output logic                      o_cmd_set_mem,
    output logic                      o_cmd_set_decim,
    output logic [CMD_PARAM_SIZE-1:0] o_cmd_parameter,
    output logic                      o_frame_error,
    output logic [ERR_COUNT_SIZE-1:0] o_err_count,
    output logic                      o_busy
);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_CMD     = 2'd1,
        ST_CHECK   = 2'd2,
        ST_PENDING = 2'd3
    } state_t;

    localparam int                      TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0]        TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ERR_COUNT_SIZE-1:0] ERR_MAX = {ERR_COUNT_SIZE{1'b1}};

    // Flag bit 0 is reset, bit 5 is set_decim; unknown opcodes give no flag.
    function automatic logic [5:0] decode_flags(input logic [3:0] opcode);
        logic [5:0] flags;
        case (opcode)
            4'd1:    flags = 6'b000001;
            4'd2:    flags = 6'b000010;
            4'd3:    flags = 6'b000100;
            4'd4:    flags = 6'b001000;
            4'd5:    flags = 6'b010000;
            4'd6:    flags = 6'b100000;
            default: flags = 6'b000000;
        endcase
        return flags;
    endfunction

    state_t                    state_q, state_d;
    logic [DATA_SIZE-1:0]      shadow_q, shadow_d;
    logic [TMO_W-1:0]          tmo_q, tmo_d;
    logic [5:0]                flags_q, flags_d;
    logic [CMD_PARAM_SIZE-1:0] param_q, param_d;
    logic                      valid_q, valid_d;
    logic                      frame_error_q, frame_error_d;
    logic [ERR_COUNT_SIZE-1:0] err_count_q, err_count_d;
    logic                      err_evt_s;

    // Next-state, shadow, timeout and error-event logic.
    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        tmo_d     = {TMO_W{1'b0}};
        flags_d   = flags_q;
        param_d   = param_q;
        err_evt_s = 1'b0;
        case (state_q)
            ST_HUNT: begin
                if (i_rx_valid && (i_rx_data == SYNC_BYTE)) begin
                    state_d = ST_CMD;
                end else begin
                    state_d = ST_HUNT;
                end
            end
            ST_CMD: begin
                if (i_rx_valid) begin
                    shadow_d = i_rx_data;
                    state_d  = ST_CHECK;
                end else if (tmo_q == TMO_LAST) begin
                    err_evt_s = 1'b1;
                    state_d   = ST_HUNT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_CHECK: begin
                if (i_rx_valid) begin
                    if (i_rx_data == (SYNC_BYTE ^ shadow_q)) begin
                        flags_d = decode_flags(shadow_q[DATA_SIZE-1 -: 4]);
                        param_d = shadow_q[CMD_PARAM_SIZE-1:0];
                        state_d = ST_PENDING;
                    end else begin
                        err_evt_s = 1'b1;
                        state_d   = ST_HUNT;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_evt_s = 1'b1;
                    state_d   = ST_HUNT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_PENDING: begin
                // A byte here is dropped even on the cycle the FSM accepts.
                err_evt_s = i_rx_valid;
                if (i_status == STATUS_CMD_PARSE) begin
                    state_d = ST_HUNT;
                end else begin
                    state_d = ST_PENDING;
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase

        valid_d       = (state_d == ST_PENDING);
        frame_error_d = err_evt_s;
        if (err_evt_s && (err_count_q != ERR_MAX)) begin
            err_count_d = err_count_q + ERR_COUNT_SIZE'(1);
        end else begin
            err_count_d = err_count_q;
        end
    end

    // State and registered-output flops.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q       <= ST_HUNT;
            shadow_q      <= {DATA_SIZE{1'b0}};
            tmo_q         <= {TMO_W{1'b0}};
            flags_q       <= 6'b000000;
            param_q       <= {CMD_PARAM_SIZE{1'b0}};
            valid_q       <= 1'b0;
            frame_error_q <= 1'b0;
            err_count_q   <= {ERR_COUNT_SIZE{1'b0}};
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            tmo_q         <= tmo_d;
            flags_q       <= flags_d;
            param_q       <= param_d;
            valid_q       <= valid_d;
            frame_error_q <= frame_error_d;
            err_count_q   <= err_count_d;
        end
    end

    assign o_cmd_valid     = valid_q;
    assign o_cmd_reset     = flags_q[0];
    assign o_cmd_sample    = flags_q[1];
    assign o_cmd_dump_mem  = flags_q[2];
    assign o_cmd_clean_mem = flags_q[3];
    assign o_cmd_set_mem   = flags_q[4];
    assign o_cmd_set_decim = flags_q[5];
    assign o_cmd_parameter = param_q;
    assign o_frame_error   = frame_error_q;
    assign o_err_count     = err_count_q;
    assign o_busy          = (state_q != ST_HUNT);

endmodule
